ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the forwarding unit.
- Consumes the 2-bit forwarding selects, muxes operands from the regfile, EX/MEM or MEM/WB, and runs the ALU.
- Resolves branches and jumps combinationally and registers results into the EX/MEM pipeline register, with stall and flush control.
- Its registered ALU result is also the EX/MEM forwarding source fed back into its own operand muxes.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_PLUS4_UNUSED, none. Block has no other parameters.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold every EX/MEM register.
- flush  in  1  load a bubble into EX/MEM.
- id_ex_valid  in  1  instruction in EX is real.
- id_ex_pc  in  XLEN  instruction PC.
- id_ex_rs1_data  in  XLEN  regfile rs1 value.
- id_ex_rs2_data  in  XLEN  regfile rs2 value.
- id_ex_imm  in  XLEN  sign-extended immediate.
- id_ex_rd  in  5  destination register.
- id_ex_alu_op  in  4  ALU operation code.
- id_ex_a_sel  in  1  0 = fwd rs1, 1 = pc.
- id_ex_b_sel  in  1  0 = fwd rs2, 1 = imm.
- id_ex_reg_write / id_ex_mem_read / id_ex_mem_write / id_ex_branch / id_ex_jal / id_ex_jalr  in  1 each  control bits.
- id_ex_funct3  in  3  branch condition / memory size.
- fwd_rs1, fwd_rs2  in  2  selects: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 treated as 00.
- mem_wb_fwd_data  in  XLEN  writeback-stage data.
- branch_taken  out  1  combinational redirect request.
- branch_target  out  XLEN  combinational redirect PC.
- ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write  out  1  registered controls.
- ex_mem_alu_result  out  XLEN  registered result; also internal EX/MEM forward source.
- ex_mem_store_data  out  XLEN  registered forwarded rs2.
- ex_mem_rd  out  5  registered destination.
- ex_mem_funct3  out  3  registered funct3.

Behaviour:
- Reset: rst=1 at a clock edge clears every ex_mem_* output to 0. rst is highest priority, including mid-stall.
- Operand mux: fwd_a = select(fwd_rs1) over {id_ex_rs1_data, ex_mem_alu_result, mem_wb_fwd_data}; fwd_b likewise with fwd_rs2.
- ALU inputs: A = a_sel ? pc : fwd_a; B = b_sel ? imm : fwd_b.
- ALU ops:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - 11-15 produce 0.
  - Shifts use B[4:0]. Arithmetic wraps modulo 2^32.
- Result: jal|jalr -> pc+4; otherwise ALU out. Store data = fwd_b (never imm).
- Branch compare on fwd_a vs fwd_b by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010/011 never taken.
- Redirect:
  - branch_taken = id_ex_valid & !stall & ((branch & cond) | jal | jalr).
  - branch_target = jalr ? ((fwd_a+imm) & ~1) : pc+imm.
  - Misaligned targets are not trapped.
- EX/MEM update priority each edge: rst > stall (hold all, flush ignored that cycle) > flush (bubble) > load.
- Bubble: valid, reg_write, mem_read, mem_write = 0; data fields = 0.
- Load with id_ex_valid=0: control bits gated to 0, data loaded as-is.
- Latency: one cycle from EX inputs to ex_mem_* outputs; redirect is zero-cycle.

Decomposition:
- Shared package holds:
  - ALU op constants (ALU_ADD..ALU_PASSB).
  - Forward select constants (FWD_NONE=00, FWD_EXMEM=01, FWD_MEMWB=10), matching the forwarding unit.
  - Branch funct3 constants.
- One combinational sub-module, ex_alu (A, B, op -> result). Compare and EX/MEM register stay in ex_stage.

Test Plan:
- Reset: rst high 2 cycles with random inputs -> all ex_mem_* = 0, ex_mem_valid = 0.
- EX/MEM forward: ADD rd=3, rs1=5, rs2=7 -> ex_mem_alu_result=12. Next SUB with fwd_rs1=01, rs1_data=0, rs2_data=2 -> result 10.
- MEM/WB forward: fwd_rs2=10, mem_wb_fwd_data=0x100, rs1=1, ADD -> 0x101. Same with fwd_rs2=11, rs2_data=4 -> 5.
- Branch: BLT, fwd_a=0xFFFFFFFF, fwd_b=1, pc=0x40, imm=0x10 -> branch_taken=1, target 0x50. BLTU same operands -> taken=0. Any case with stall=1 -> taken=0.
- JALR: pc=0x80, rs1=0x1003, imm=4 -> target 0x1006, next-cycle result 0x84, reg_write=1.
- Stall/flush: stall 3 cycles with changing inputs -> outputs frozen. stall+flush -> frozen. flush alone -> valid=0, reg_write=0, mem_write=0, result=0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared ALU op codes, forward selects and branch funct3 codes
package ex_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, pipeline control and EX/MEM outputs of the execute stage
interface ex_stage_if #(parameter int XLEN = 32);
    logic            stall;
    logic            flush;
    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc;
    logic [XLEN-1:0] id_ex_rs1_data;
    logic [XLEN-1:0] id_ex_rs2_data;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rd;
    logic [3:0]      id_ex_alu_op;
    logic            id_ex_a_sel;
    logic            id_ex_b_sel;
    logic            id_ex_reg_write;
    logic            id_ex_mem_read;
    logic            id_ex_mem_write;
    logic            id_ex_branch;
    logic            id_ex_jal;
    logic            id_ex_jalr;
    logic [2:0]      id_ex_funct3;
    logic [1:0]      fwd_rs1;
    logic [1:0]      fwd_rs2;
    logic [XLEN-1:0] mem_wb_fwd_data;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            ex_mem_valid;
    logic            ex_mem_reg_write;
    logic            ex_mem_mem_read;
    logic            ex_mem_mem_write;
    logic [XLEN-1:0] ex_mem_alu_result;
    logic [XLEN-1:0] ex_mem_store_data;
    logic [4:0]      ex_mem_rd;
    logic [2:0]      ex_mem_funct3;
    modport master (
        output stall, flush, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rd, id_ex_alu_op, id_ex_a_sel, id_ex_b_sel, id_ex_reg_write, id_ex_mem_read,
               id_ex_mem_write, id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_funct3,
               fwd_rs1, fwd_rs2, mem_wb_fwd_data,
        input  branch_taken, branch_target, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read,
               ex_mem_mem_write, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_funct3
    );
    modport slave (
        input  stall, flush, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rd, id_ex_alu_op, id_ex_a_sel, id_ex_b_sel, id_ex_reg_write, id_ex_mem_read,
               id_ex_mem_write, id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_funct3,
               fwd_rs1, fwd_rs2, mem_wb_fwd_data,
        output branch_taken, branch_target, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read,
               ex_mem_mem_write, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_funct3
    );
endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational RV32I integer ALU; unused op codes yield zero
module ex_alu
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] y
);
    logic [4:0] shamt;
    assign shamt = b[4:0];
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  y = XLEN'(a < b);
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $signed(a) >>> shamt;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic   clk,
    input logic   rst,
    ex_stage_if.slave bus
);
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_y, pc_plus4;
    logic            eq, lt, ltu, cond, ctl;
    // the EX/MEM source is our own registered result
    assign fwd_a = (bus.fwd_rs1 == FWD_EXMEM) ? bus.ex_mem_alu_result :
                   (bus.fwd_rs1 == FWD_MEMWB) ? bus.mem_wb_fwd_data : bus.id_ex_rs1_data;
    assign fwd_b = (bus.fwd_rs2 == FWD_EXMEM) ? bus.ex_mem_alu_result :
                   (bus.fwd_rs2 == FWD_MEMWB) ? bus.mem_wb_fwd_data : bus.id_ex_rs2_data;
    assign op_a = bus.id_ex_a_sel ? bus.id_ex_pc : fwd_a;
    assign op_b = bus.id_ex_b_sel ? bus.id_ex_imm : fwd_b;
    assign pc_plus4 = bus.id_ex_pc + XLEN'(4);
    ex_alu #(.XLEN(XLEN)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (bus.id_ex_alu_op),
        .y  (alu_y)
    );
    assign eq  = fwd_a == fwd_b;
    assign lt  = $signed(fwd_a) < $signed(fwd_b);
    assign ltu = fwd_a < fwd_b;
    always_comb begin
        cond = (bus.id_ex_funct3 == F3_BEQ)  ? eq   :
               (bus.id_ex_funct3 == F3_BNE)  ? !eq  :
               (bus.id_ex_funct3 == F3_BLT)  ? lt   :
               (bus.id_ex_funct3 == F3_BGE)  ? !lt  :
               (bus.id_ex_funct3 == F3_BLTU) ? ltu  :
               (bus.id_ex_funct3 == F3_BGEU) ? !ltu : 1'b0;
    end
    assign bus.branch_taken  = bus.id_ex_valid && !bus.stall &&
                               ((bus.id_ex_branch && cond) || bus.id_ex_jal || bus.id_ex_jalr);
    assign bus.branch_target = bus.id_ex_jalr ? ((fwd_a + bus.id_ex_imm) & ~XLEN'(1))
                                              : bus.id_ex_pc + bus.id_ex_imm;
    assign ctl = bus.id_ex_valid;
    // stall outranks flush, so a flush during a stall is dropped
    always_ff @(posedge clk) begin
        if (rst || (bus.flush && !bus.stall)) begin
            bus.ex_mem_valid      <= 1'b0;
            bus.ex_mem_reg_write  <= 1'b0;
            bus.ex_mem_mem_read   <= 1'b0;
            bus.ex_mem_mem_write  <= 1'b0;
            bus.ex_mem_alu_result <= '0;
            bus.ex_mem_store_data <= '0;
            bus.ex_mem_rd         <= '0;
            bus.ex_mem_funct3     <= '0;
        end else if (!bus.stall) begin
            bus.ex_mem_valid      <= ctl;
            bus.ex_mem_reg_write  <= ctl && bus.id_ex_reg_write;
            bus.ex_mem_mem_read   <= ctl && bus.id_ex_mem_read;
            bus.ex_mem_mem_write  <= ctl && bus.id_ex_mem_write;
            bus.ex_mem_alu_result <= (bus.id_ex_jal || bus.id_ex_jalr) ? pc_plus4 : alu_y;
            bus.ex_mem_store_data <= fwd_b;
            bus.ex_mem_rd         <= bus.id_ex_rd;
            bus.ex_mem_funct3     <= bus.id_ex_funct3;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a queued scoreboard for the EX/MEM register
module tb_ex_stage;
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   n = 0;
    exp_t q[$];
    exp_t zero_e, held;
    ex_stage_if #(.XLEN(32)) bus ();
    ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t mk(input logic v, rw, mr, mw, input logic [31:0] res, sd,
                                input logic [4:0] rd, input logic [2:0] f3);
        exp_t e;
        e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw;
        e.res = res; e.sd = sd; e.rd = rd; e.f3 = f3;
        return e;
    endfunction
    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e, a;
            e = q.pop_front();
            a.valid = bus.ex_mem_valid;      a.rw = bus.ex_mem_reg_write;
            a.mr    = bus.ex_mem_mem_read;   a.mw = bus.ex_mem_mem_write;
            a.res   = bus.ex_mem_alu_result; a.sd = bus.ex_mem_store_data;
            a.rd    = bus.ex_mem_rd;         a.f3 = bus.ex_mem_funct3;
            chk($sformatf("exmem#%0d", n), 80'(a), 80'(e));
            n++;
        end
    end
    task automatic tick(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask
    task automatic clr();
        bus.stall = 0; bus.flush = 0; bus.id_ex_valid = 1;
        bus.id_ex_pc = 0; bus.id_ex_rs1_data = 0; bus.id_ex_rs2_data = 0; bus.id_ex_imm = 0;
        bus.id_ex_rd = 0; bus.id_ex_alu_op = 0; bus.id_ex_a_sel = 0; bus.id_ex_b_sel = 0;
        bus.id_ex_reg_write = 0; bus.id_ex_mem_read = 0; bus.id_ex_mem_write = 0;
        bus.id_ex_branch = 0; bus.id_ex_jal = 0; bus.id_ex_jalr = 0; bus.id_ex_funct3 = 0;
        bus.fwd_rs1 = 0; bus.fwd_rs2 = 0; bus.mem_wb_fwd_data = 0;
    endtask
    task automatic rnd();
        bus.stall = 1'($urandom); bus.flush = 1'($urandom); bus.id_ex_valid = 1'($urandom);
        bus.id_ex_pc = $urandom; bus.id_ex_rs1_data = $urandom; bus.id_ex_rs2_data = $urandom;
        bus.id_ex_imm = $urandom; bus.id_ex_rd = 5'($urandom); bus.id_ex_alu_op = 4'($urandom);
        bus.id_ex_a_sel = 1'($urandom); bus.id_ex_b_sel = 1'($urandom);
        bus.id_ex_reg_write = 1'($urandom); bus.id_ex_mem_read = 1'($urandom);
        bus.id_ex_mem_write = 1'($urandom); bus.id_ex_branch = 1'($urandom);
        bus.id_ex_jal = 1'($urandom); bus.id_ex_jalr = 1'($urandom);
        bus.id_ex_funct3 = 3'($urandom); bus.fwd_rs1 = 2'($urandom_range(0, 3));
        bus.fwd_rs2 = 2'($urandom_range(0, 3)); bus.mem_wb_fwd_data = $urandom;
    endtask
    task automatic alu_t(input logic [3:0] op, input logic [31:0] a, b, y);
        clr();
        bus.id_ex_alu_op = op; bus.id_ex_rs1_data = a; bus.id_ex_rs2_data = b;
        bus.id_ex_rd = 6; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, y, b, 6, 0));
    endtask
    task automatic br(input logic [2:0] f3, input logic tk);
        clr();
        bus.id_ex_branch = 1; bus.id_ex_funct3 = f3;
        bus.id_ex_rs1_data = 32'hFFFF_FFFF; bus.id_ex_rs2_data = 1;
        bus.id_ex_pc = 32'h40; bus.id_ex_imm = 32'h10;
        #1;
        chk($sformatf("br_taken_f3_%0d", f3), 80'(bus.branch_taken), 80'(tk));
        chk($sformatf("br_target_f3_%0d", f3), 80'(bus.branch_target), 80'(32'h50));
        tick(mk(1, 0, 0, 0, 0, 1, 0, f3));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        zero_e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        repeat (2) begin
            rnd();
            tick(zero_e);
        end
        rst = 0;
        clr();
        bus.id_ex_rs1_data = 5; bus.id_ex_rs2_data = 7; bus.id_ex_rd = 3; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 12, 7, 3, 0));
        clr();
        bus.id_ex_alu_op = 1; bus.fwd_rs1 = 2'b01; bus.id_ex_rs2_data = 2;
        bus.id_ex_rd = 4; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 10, 2, 4, 0));
        clr();
        bus.fwd_rs2 = 2'b10; bus.mem_wb_fwd_data = 32'h100; bus.id_ex_rs1_data = 1;
        bus.id_ex_rs2_data = 32'h55; bus.id_ex_rd = 5; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 32'h101, 32'h100, 5, 0));
        clr();
        bus.fwd_rs2 = 2'b11; bus.mem_wb_fwd_data = 32'h100; bus.id_ex_rs1_data = 1;
        bus.id_ex_rs2_data = 4; bus.id_ex_rd = 5; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 5, 4, 5, 0));
        alu_t(2, 3, 33, 6);
        alu_t(3, 32'hFFFF_FFFF, 1, 1);
        alu_t(4, 32'hFFFF_FFFF, 1, 0);
        alu_t(5, 32'hF0F0, 32'hFF00, 32'h0FF0);
        alu_t(6, 32'h8000_0000, 32'h24, 32'h0800_0000);
        alu_t(7, 32'h8000_0000, 32'h24, 32'hF800_0000);
        alu_t(8, 32'hF0F0, 32'hFF00, 32'hFFF0);
        alu_t(9, 32'hF0F0, 32'hFF00, 32'hF000);
        alu_t(1, 0, 1, 32'hFFFF_FFFF);
        alu_t(0, 32'hFFFF_FFFF, 2, 1);
        alu_t(10, 5, 3, 3);
        alu_t(12, 5, 3, 0);
        alu_t(15, 5, 3, 0);
        clr();
        bus.id_ex_alu_op = 10; bus.id_ex_b_sel = 1; bus.id_ex_imm = 32'h1234_5000;
        bus.id_ex_rs2_data = 32'h77; bus.id_ex_rd = 7; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 32'h1234_5000, 32'h77, 7, 0));
        clr();
        bus.id_ex_a_sel = 1; bus.id_ex_b_sel = 1; bus.id_ex_pc = 32'h200; bus.id_ex_imm = 8;
        bus.id_ex_rs1_data = 32'h999; bus.id_ex_rd = 7; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 32'h208, 0, 7, 0));
        clr();
        bus.id_ex_mem_read = 1; bus.id_ex_reg_write = 1; bus.id_ex_funct3 = 2;
        bus.id_ex_rs1_data = 32'h1000; bus.id_ex_b_sel = 1; bus.id_ex_imm = 4; bus.id_ex_rd = 8;
        tick(mk(1, 1, 1, 0, 32'h1004, 0, 8, 2));
        clr();
        bus.id_ex_valid = 0; bus.id_ex_mem_write = 1; bus.id_ex_reg_write = 1; bus.id_ex_jal = 1;
        bus.id_ex_pc = 32'h300; bus.id_ex_rs2_data = 32'hAB; bus.id_ex_rd = 9;
        #1;
        chk("invalid_jal_taken", 80'(bus.branch_taken), 80'(1'b0));
        tick(mk(0, 0, 0, 0, 32'h304, 32'hAB, 9, 0));
        br(3'b100, 1);
        br(3'b110, 0);
        br(3'b101, 0);
        br(3'b111, 1);
        br(3'b000, 0);
        br(3'b001, 1);
        br(3'b010, 0);
        br(3'b011, 0);
        clr();
        bus.id_ex_jalr = 1; bus.id_ex_pc = 32'h80; bus.id_ex_rs1_data = 32'h1003;
        bus.id_ex_imm = 4; bus.id_ex_b_sel = 1; bus.id_ex_reg_write = 1; bus.id_ex_rd = 1;
        #1;
        chk("jalr_taken", 80'(bus.branch_taken), 80'(1'b1));
        chk("jalr_target", 80'(bus.branch_target), 80'(32'h1006));
        tick(mk(1, 1, 0, 0, 32'h84, 0, 1, 0));
        clr();
        bus.id_ex_jal = 1; bus.id_ex_pc = 32'h100; bus.id_ex_imm = 32'h20;
        bus.id_ex_reg_write = 1; bus.id_ex_rd = 1;
        #1;
        chk("jal_taken", 80'(bus.branch_taken), 80'(1'b1));
        chk("jal_target", 80'(bus.branch_target), 80'(32'h120));
        held = mk(1, 1, 0, 0, 32'h104, 0, 1, 0);
        tick(held);
        for (int i = 0; i < 3; i++) begin
            rnd();
            bus.stall = 1; bus.flush = 0; bus.id_ex_valid = 1;
            if (i == 0) begin
                bus.id_ex_branch = 1; bus.id_ex_funct3 = 3'b100; bus.fwd_rs1 = 0; bus.fwd_rs2 = 0;
                bus.id_ex_rs1_data = 32'hFFFF_FFFF; bus.id_ex_rs2_data = 1;
            end else begin
                bus.id_ex_jal = 1;
            end
            #1;
            chk($sformatf("stall_taken_%0d", i), 80'(bus.branch_taken), 80'(1'b0));
            tick(held);
        end
        clr();
        bus.stall = 1; bus.flush = 1; bus.id_ex_rs1_data = 9; bus.id_ex_reg_write = 1;
        tick(held);
        clr();
        bus.flush = 1; bus.id_ex_rs1_data = 5; bus.id_ex_reg_write = 1; bus.id_ex_mem_write = 1;
        bus.id_ex_rd = 3;
        tick(zero_e);
        clr();
        bus.id_ex_rs1_data = 1; bus.id_ex_rs2_data = 2; bus.id_ex_rd = 2; bus.id_ex_reg_write = 1;
        tick(mk(1, 1, 0, 0, 3, 2, 2, 0));
        clr();
        rst = 1; bus.stall = 1;
        tick(zero_e);
        rst = 0;
        clr();
        @(negedge clk);
        chk("queue_drained", 80'(q.size()), 80'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
